// File: rtl/snpu_pkg.sv
// Shared types and constants for the SNPU random-bank harvester.
package snpu_pkg;

  localparam int unsigned RND_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFreeze,
    StDebias,
    StRun
  } state_e;

endpackage

// File: rtl/rnd_fifo.sv
// Small synchronous byte FIFO with a registered store and combinational head.
// A push while full is accepted only if a pop happens in the same cycle.
module rnd_fifo
  import snpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PtrW:0]     wptr_q, rptr_q;
  logic              do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    head    = empty ? '0 : mem_q[rptr_q[PtrW-1:0]];
  end

  // Pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage; when full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rnd_harvester.sv
// Freezes the random bank, captures one word, Von Neumann debiases it a pair
// per cycle, packs surviving bits into bytes and queues them for a consumer.
module rnd_harvester
  import snpu_pkg::*;
#(
  parameter int unsigned RND_N      = 32,
  parameter int unsigned ADDR_W     = $clog2(RND_N),
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned RUN_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              freeze,
  output logic [ADDR_W-1:0] addr,
  input  logic [RND_W-1:0]  rnd_in,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              clr
);

  state_e              state_q, state_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RND_W-1:0]    word_q;
  // Only the low 7 bits of the accumulator are ever needed: the 8th bit of a
  // byte is the one arriving on the push edge.
  logic [BYTE_W-2:0]   acc_q, acc_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic                ovf_q;
  logic                capture, addr_inc;
  logic [3:0]          pair_idx;
  logic [1:0]          pair;
  logic                emit, emit_bit, push;
  logic [BYTE_W-1:0]   push_data;
  logic                fifo_full, fifo_empty, fifo_drop;

  // Next-state and sequencing for the freeze / debias / run cycle.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    capture  = 1'b0;
    addr_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StFreeze;
          cyc_d   = '0;
        end
      end
      StFreeze: begin
        if (cyc_q == 16'(SETTLE - 1)) begin
          state_d = StDebias;
          cyc_d   = '0;
          capture = 1'b1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StDebias: begin
        if (cyc_q == 16'd7) begin
          state_d = StRun;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StRun: begin
        if (cyc_q == 16'(RUN_CYCLES - 1)) begin
          addr_inc = 1'b1;
          cyc_d    = '0;
          state_d  = en ? StFreeze : StIdle;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = '0;
      end
    endcase
  end

  // Debias the current pair and pack emitted bits; a byte leaves on the 8th bit.
  always_comb begin
    freeze    = (state_q == StFreeze);
    pair_idx  = {cyc_q[2:0], 1'b0};
    pair      = word_q[pair_idx +: 2];
    emit      = (state_q == StDebias) && (pair[1] ^ pair[0]);
    emit_bit  = pair[1];
    push      = emit && (bcnt_q == 3'd7);
    push_data = {acc_q, emit_bit};
    acc_d     = emit ? {acc_q[BYTE_W-3:0], emit_bit} : acc_q;
    bcnt_d    = emit ? bcnt_q + 3'd1 : bcnt_q;
    addr_d    = addr_q;
    if (addr_inc) begin
      addr_d = (addr_q == ADDR_W'(RND_N - 1)) ? '0 : addr_q + 1'b1;
    end
  end

  // Controller, captured word, accumulator and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      bcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      if (capture) word_q <= rnd_in;
      acc_q   <= acc_d;
      bcnt_q  <= bcnt_d;
      // A drop wins over a same-cycle clear.
      ovf_q   <= fifo_drop | (ovf_q & ~clr);
    end
  end

  rnd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (out_ready),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign addr      = addr_q;
  assign out_valid = !fifo_empty;
  assign overflow  = ovf_q;

endmodule

// File: doc/rnd_harvester.md
# rnd_harvester

Sequential reader for the SNPU free-running random bank. It drives the bank's freeze and address lines, waits for the frozen word to settle, and captures the 16-bit word. It then Von Neumann debiases the word one bit-pair per cycle, packs the surviving bits into bytes, and buffers them in a small FIFO with a valid/ready output. It sits between the random bank and any on-chip or pin-level consumer of entropy bytes.

## Interface
- RND_N, 32, number of generator words in the bank
- ADDR_W, $clog2(RND_N), address width
- SETTLE, 4, cycles freeze is held before capture (min 2)
- RUN_CYCLES, 8, cycles the bank free-runs between captures (min 1)
- FIFO_DEPTH, 4, output byte FIFO depth (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- en  in  1  harvesting enable
- freeze  out  1  to bank G; 1 = bank held
- addr  out  ADDR_W  bank word select
- rnd_in  in  16  selected bank word
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head byte
- overflow  out  1  sticky: a byte was dropped
- clr  in  1  synchronous clear of overflow

## Operation
- **Reset values:** FSM=IDLE, freeze=0, addr=0, FIFO empty, out_valid=0, out_data=0, overflow=0, accumulator and bit count cleared.
- **IDLE:**
  - freeze=0.
  - en=1 → FREEZE.
- **FREEZE:**
  - freeze=1; addr held; stays SETTLE cycles.
  - On the edge leaving FREEZE, word register <= rnd_in → DEBIAS.
- **DEBIAS:**
  - freeze=0; exactly 8 cycles, pair k=0..7 in order.
  - Pair k = (w[2k+1], w[2k]).
  - (0,1) emits bit 0; (1,0) emits bit 1; (0,0) and (1,1) emit nothing.
  - An emitted bit shifts in at the LSB: acc <= {acc[6:0], b}; bit count increments.
  - When count reaches 8, the byte is pushed to the FIFO and count returns to 0 on the same edge.
  - acc and count persist across words and across IDLE.
- **RUN:**
  - freeze=0 for RUN_CYCLES cycles.
  - On exit, addr <= addr+1, wrapping RND_N-1 → 0.
  - Next state is FREEZE if en=1, else IDLE.
- **en:**
  - Sampled only at the RUN exit and in IDLE.
  - Deasserting en mid-word completes the current word.
- **FIFO:**
  - out_valid = not empty; out_data = head.
  - Pop on out_valid & out_ready.
  - Push while full is dropped and sets overflow, except when a pop occurs in the same cycle. In that case the push is accepted and no overflow is recorded.
  - Simultaneous push and pop when empty: the byte is stored, valid next cycle (no bypass).
- **overflow:**
  - Set by a drop, cleared by clr.
  - Set and clr in the same cycle → overflow stays 1.

## Timing
- en rises before edge 0 (IDLE): freeze=1 during cycles 1..SETTLE.
- Capture at the end of cycle SETTLE.
- DEBIAS runs cycles SETTLE+1..SETTLE+8.
- RUN runs the next RUN_CYCLES cycles.
- Word period = SETTLE+8+RUN_CYCLES cycles (20 at defaults).
- A byte completed in a DEBIAS cycle gives out_valid=1 the following cycle.
- Pop latency is 1 cycle; back-to-back pops are allowed.
- Asynchronous reset at any point forces the reset values immediately and drops any partial byte and FIFO contents.
- rnd_in is unsynchronized. Correctness relies on the bank being frozen for ≥2 cycles before capture, so SETTLE<2 is illegal.

## Structure
- Package snpu_pkg contains:
  - the FSM state enum (IDLE, FREEZE, DEBIAS, RUN);
  - the word width constant RND_W=16;
  - the byte width 8.
- Sub-module rnd_fifo holds the parameterized synchronous FIFO: data 8, depth FIFO_DEPTH, push/pop/full/empty.
- The FSM, debiaser and accumulator stay in rnd_harvester.
- Expected size is roughly 200 RTL lines in total.

## Test plan
- Reset, then idle with en=0 for 50 cycles → freeze=0, addr=0, out_valid=0, overflow=0 throughout.
- Bank model returns 16'hAAAA, en=1, out_ready=1 → freeze high exactly 4 cycles per word; first byte 8'hFF appears with out_valid one cycle after the 8th DEBIAS cycle of word 0.
- Bank returns 16'h0009 for every address → two bits per word (0 then 1); after 4 words out_data=8'h55. Repeat with 16'hFFFF/16'h0000 → no bytes ever.
- out_ready=0, bank 16'h5555 → bytes 8'h00 fill 4 entries after 4 words; word 5 sets overflow=1; clr → overflow=0. Pulse clr together with a drop → overflow remains 1.
- en held 1 for 33 words → addr sequence 0,1,…,31,0 changes only at RUN exits. Deassert en during DEBIAS → the word finishes, then IDLE with freeze=0.
- Assert rst_n=0 asynchronously mid-DEBIAS with 2 bytes queued → outputs return to reset values before the next edge, and the first byte after re-enable needs 8 fresh bits.
